phoneme_playback_ctrl: RTL and testbench
========================================

Name: phoneme_playback_ctrl

Overview:
- Sequences playback of one phoneme stored in sample ROM: walks ROM addresses start_addr..end_addr at a programmable sample period.
- Acts as the rate scheduler in place of a free-running divided clock: all timing is single-clock enables.
- Issues ROM read strobes, then DAC load strobes one cycle later (ROM has 1-cycle registered latency).
- Sits between the phoneme/word sequencer (start/done handshake) and the sample ROM/DAC path.

Parameters:
ADDR_W, 23, ROM address width
DIV_W, 32, sample-period divisor width (clk_input cycles per sample)

Ports:
clk_input  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request playback; accepted only in IDLE
start_addr  in  ADDR_W  first sample address
end_addr  in  ADDR_W  last sample address (inclusive)
divisor  in  DIV_W  sample period in clk_input cycles
abort  in  1  synchronous stop of current playback
busy  out  1  high from acceptance until done/err/abort
rom_read  out  1  1-cycle read strobe
rom_addr  out  ADDR_W  address qualified by rom_read
dac_load  out  1  1-cycle strobe, one cycle after each rom_read
done  out  1  1-cycle pulse at normal completion
err  out  1  1-cycle pulse on rejected request

Behaviour:
- Reset: state IDLE; busy, rom_read, dac_load, done, err = 0; rom_addr = 0; period counter = 0. Reset dominates start and abort.
- All outputs are registered.
- States: IDLE, RUN, TAIL.
- IDLE, start=1 at edge E0:
  - If end_addr < start_addr: err=1 for one cycle at E0, busy stays 0, no reads.
  - Otherwise latch start_addr, end_addr and div_lat = max(divisor, 2). Values 0 and 1 clamp to 2.
  - Set busy=1, counter = div_lat-1, state RUN.
- RUN, each edge:
  - If counter == div_lat-1: rom_read=1, rom_addr=addr_ptr, counter=0.
  - Then, if addr_ptr == end_addr, go to TAIL; else addr_ptr increments.
  - Otherwise counter increments and rom_read=0.
- Timing: first rom_read is at E1 (edge after acceptance). Read k (0-based) is at E1 + k*div_lat.
- dac_load mirrors rom_read delayed by exactly one cycle, in all states, including after abort.
- TAIL: the last sample is held for a full period.
  - counter increments; at counter == div_lat-1: done=1 (one cycle), busy=0, state IDLE.
  - done rises at E_last + div_lat, where E_last is the edge of the last rom_read.
- Single-sample phoneme (start_addr == end_addr): one read at E1, done at E1 + div_lat.
- Changes to divisor/start_addr/end_addr while busy have no effect; only latched values are used.
- start while busy is ignored. start on the same edge that done is asserted is also ignored; a new start is accepted the following cycle.
- abort in RUN or TAIL: at that edge go IDLE, busy=0, rom_read=0, done=0. A dac_load already due from the prior cycle's read still fires. abort in IDLE has no effect.
- start and abort together in IDLE: start wins.
- Address arithmetic is ADDR_W unsigned. end_addr = all-ones is legal; addr_ptr never increments past end_addr, so no wrap.
- Counter is DIV_W unsigned. div_lat = 2^DIV_W-1 must work without overflow.

Test Plan:
- start_addr=0x10, end_addr=0x13, divisor=5, start at E0 -> rom_read at E1,E6,E11,E16 with addr 0x10..0x13; dac_load at E2,E7,E12,E17; done at E21; busy high E0..E20, low at E21.
- divisor=0 and divisor=1, start_addr=end_addr=0x5 -> treated as 2: read at E1, dac_load E2, done E3.
- start_addr=0x20, end_addr=0x1F -> err pulse at E0, no rom_read, busy stays 0; a valid start next cycle is accepted.
- Run 0x0..0x9 at divisor=4, assert abort on the edge of the 3rd read -> no further rom_read, no done, busy low that edge; dac_load for the 2nd read still fires; new start accepted next cycle.
- Change divisor from 4 to 9 mid-run and pulse start while busy -> read spacing stays 4; second start ignored, no restart.
- end_addr=all-ones, start_addr=all-ones minus 1, divisor=3 -> two reads, rom_addr never wraps to 0, done 3 cycles after last read; reset asserted mid-RUN -> all outputs 0 at next edge.

Source files
------------

// File: rtl/phoneme_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phoneme_playback_ctrl
// Purpose  : Plays back one phoneme from sample ROM. It walks the addresses
//            start_addr..end_addr (inclusive) at a programmable sample period,
//            using single-clock enables in place of a divided clock. It issues
//            a ROM read strobe and then a DAC load strobe one cycle later.
// Ports    : clk_input  - system clock, rising edge
//            reset      - synchronous, active-high reset
//            start      - playback request (accepted only when idle)
//            start_addr - first sample address
//            end_addr   - last sample address (inclusive)
//            divisor    - sample period in clk_input cycles (0/1 -> 2)
//            abort      - synchronous stop of the current playback
//            busy       - high from acceptance until done/abort
//            rom_read   - 1-cycle ROM read strobe
//            rom_addr   - address qualified by rom_read
//            dac_load   - rom_read delayed by one cycle
//            done       - 1-cycle pulse at normal completion
//            err        - 1-cycle pulse on a rejected request
// Revision : 1.0 - initial release
// ============================================================================
module phoneme_playback_ctrl #(
    parameter int ADDR_W = 23,
    parameter int DIV_W  = 32
) (
    input  logic              clk_input,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              abort,
    output logic              busy,
    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              dac_load,
    output logic              done,
    output logic              err
);

    localparam logic [DIV_W-1:0] c_DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_ONE     = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              busy_q, busy_d;
    logic              rom_read_q, rom_read_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              dac_load_q, dac_load_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Clamped period for a new request; a period of 1 would collide the
    // read and load strobes of consecutive samples.
    logic [DIV_W-1:0]  w_div_clamped;
    logic              w_period_end;

    assign w_div_clamped = (divisor < c_DIV_MIN) ? c_DIV_MIN : divisor;
    // div_q >= 2 whenever this is consulted, so div_q-1 never underflows and
    // the counter never needs to reach div_q itself (no overflow at all-ones).
    assign w_period_end  = (cnt_q == (div_q - c_ONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        busy_d     = busy_q;
        rom_read_d = 1'b0;
        rom_addr_d = rom_addr_q;
        dac_load_d = rom_read_q;   // ROM data is valid one cycle after the read
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (end_addr < start_addr) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = start_addr;
                        end_d   = end_addr;
                        div_d   = w_div_clamped;
                        // Preloading to period-1 makes the first read land on
                        // the very next edge.
                        cnt_d   = w_div_clamped - c_ONE;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (w_period_end) begin
                    rom_read_d = 1'b1;
                    rom_addr_d = ptr_q;
                    cnt_d      = '0;
                    if (ptr_q == end_q) begin
                        state_d = S_TAIL;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end

            S_TAIL: begin
                // Hold the last sample on the DAC for one full period.
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (w_period_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_input) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= c_DIV_MIN;
            ptr_q      <= '0;
            end_q      <= '0;
            busy_q     <= 1'b0;
            rom_read_q <= 1'b0;
            rom_addr_q <= '0;
            dac_load_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            busy_q     <= busy_d;
            rom_read_q <= rom_read_d;
            rom_addr_q <= rom_addr_d;
            dac_load_q <= dac_load_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign rom_read = rom_read_q;
    assign rom_addr = rom_addr_q;
    assign dac_load = dac_load_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phoneme_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phoneme_playback_ctrl
// Purpose  : Directed bench for phoneme_playback_ctrl. Stimulus pushes the
//            expected strobe events (cycle stamp, address) into per-strobe
//            queues; a negedge monitor pops and compares whenever a strobe
//            appears, and flags expected events that are overdue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phoneme_playback_ctrl;

    localparam int ADDR_W = 23;
    localparam int DIV_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [DIV_W-1:0]  divisor;
    logic              abort;
    logic              busy;
    logic              rom_read;
    logic [ADDR_W-1:0] rom_addr;
    logic              dac_load;
    logic              done;
    logic              err;

    phoneme_playback_ctrl #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .clk_input  (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .divisor    (divisor),
        .abort      (abort),
        .busy       (busy),
        .rom_read   (rom_read),
        .rom_addr   (rom_addr),
        .dac_load   (dac_load),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              c;
        logic [ADDR_W-1:0] a;
    } rd_ev_t;

    rd_ev_t q_rd[$];
    int     q_dac[$];
    int     q_done[$];
    int     q_err[$];

    rd_ev_t ev;
    int     ec;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        // Expected events whose cycle has passed without the strobe.
        while (q_rd.size() > 0 && q_rd[0].c < cyc) begin
            ev = q_rd.pop_front();
            checks++; errors++;
            $display("FAIL rom_read missing: got none at cyc %0d, required addr %h", ev.c, ev.a);
        end
        while (q_dac.size() > 0 && q_dac[0] < cyc) begin
            ec = q_dac.pop_front();
            checks++; errors++;
            $display("FAIL dac_load missing: got none, required at cyc %0d", ec);
        end
        while (q_done.size() > 0 && q_done[0] < cyc) begin
            ec = q_done.pop_front();
            checks++; errors++;
            $display("FAIL done missing: got none, required at cyc %0d", ec);
        end
        while (q_err.size() > 0 && q_err[0] < cyc) begin
            ec = q_err.pop_front();
            checks++; errors++;
            $display("FAIL err missing: got none, required at cyc %0d", ec);
        end

        if (rom_read) begin
            checks++;
            if (q_rd.size() == 0) begin
                errors++;
                $display("FAIL rom_read unexpected: got read addr %h at cyc %0d, required none", rom_addr, cyc);
            end else begin
                ev = q_rd.pop_front();
                if (ev.c != cyc || ev.a !== rom_addr) begin
                    errors++;
                    $display("FAIL rom_read: got cyc %0d addr %h, required cyc %0d addr %h", cyc, rom_addr, ev.c, ev.a);
                end
            end
        end
        if (dac_load) begin
            checks++;
            if (q_dac.size() == 0) begin
                errors++;
                $display("FAIL dac_load unexpected: got pulse at cyc %0d, required none", cyc);
            end else begin
                ec = q_dac.pop_front();
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL dac_load: got cyc %0d, required cyc %0d", cyc, ec);
                end
            end
        end
        if (done) begin
            checks++;
            if (q_done.size() == 0) begin
                errors++;
                $display("FAIL done unexpected: got pulse at cyc %0d, required none", cyc);
            end else begin
                ec = q_done.pop_front();
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL done: got cyc %0d, required cyc %0d", cyc, ec);
                end
            end
        end
        if (err) begin
            checks++;
            if (q_err.size() == 0) begin
                errors++;
                $display("FAIL err unexpected: got pulse at cyc %0d, required none", cyc);
            end else begin
                ec = q_err.pop_front();
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL err: got cyc %0d, required cyc %0d", cyc, ec);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // Presents a request for one edge; e0 is the acceptance edge number.
    task automatic issue(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                         input logic [DIV_W-1:0] dv, output int e0);
        start_addr = sa;
        end_addr   = ea;
        divisor    = dv;
        start      = 1'b1;
        step();
        start      = 1'b0;
        e0         = cyc;
    endtask

    task automatic exp_rd(input int c, input logic [ADDR_W-1:0] a);
        rd_ev_t e;
        e.c = c;
        e.a = a;
        q_rd.push_back(e);
        q_dac.push_back(c + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int e1;

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        divisor    = '0;
        repeat (3) step();

        chk("reset busy",     32'(busy),     32'h0);
        chk("reset rom_read", 32'(rom_read), 32'h0);
        chk("reset rom_addr", 32'(rom_addr), 32'h0);
        chk("reset dac_load", 32'(dac_load), 32'h0);
        chk("reset done",     32'(done),     32'h0);
        chk("reset err",      32'(err),      32'h0);
        reset = 1'b0;
        step();

        // Basic run, period 5.
        issue(23'h10, 23'h13, 32'd5, e0);
        for (int k = 0; k < 4; k++) exp_rd(e0 + 1 + 5 * k, 23'h10 + 23'(k));
        q_done.push_back(e0 + 21);
        chk("run busy at E0", 32'(busy), 32'h1);
        goto(e0 + 20);
        chk("run busy at E20", 32'(busy), 32'h1);
        goto(e0 + 21);
        chk("run busy at E21", 32'(busy), 32'h0);

        // Divisor 0 clamps to 2, then divisor 1 back-to-back.
        issue(23'h5, 23'h5, 32'd0, e0);
        exp_rd(e0 + 1, 23'h5);
        q_done.push_back(e0 + 3);
        goto(e0 + 3);
        chk("div0 busy after done", 32'(busy), 32'h0);
        issue(23'h5, 23'h5, 32'd1, e0);
        exp_rd(e0 + 1, 23'h5);
        q_done.push_back(e0 + 3);
        goto(e0 + 3);

        // Rejected request, then valid one on the next cycle.
        issue(23'h20, 23'h1F, 32'd7, e0);
        q_err.push_back(e0);
        chk("err busy", 32'(busy), 32'h0);
        issue(23'h30, 23'h30, 32'd2, e0);
        exp_rd(e0 + 1, 23'h30);
        q_done.push_back(e0 + 3);
        chk("after err busy", 32'(busy), 32'h1);
        goto(e0 + 3);

        // Abort on the edge of the 3rd read.
        issue(23'h0, 23'h9, 32'd4, e0);
        exp_rd(e0 + 1, 23'h0);
        exp_rd(e0 + 5, 23'h1);
        goto(e0 + 8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort rom_read", 32'(rom_read), 32'h0);
        issue(23'h40, 23'h40, 32'd3, e1);
        exp_rd(e1 + 1, 23'h40);
        q_done.push_back(e1 + 4);
        goto(e1 + 4);

        // Abort the edge after a read: that read's dac_load still fires.
        issue(23'h50, 23'h55, 32'd3, e0);
        exp_rd(e0 + 1, 23'h50);
        exp_rd(e0 + 4, 23'h51);
        goto(e0 + 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort2 busy", 32'(busy), 32'h0);
        goto(e0 + 9);

        // Divisor change and start pulse while busy are ignored.
        issue(23'h60, 23'h63, 32'd4, e0);
        for (int k = 0; k < 4; k++) exp_rd(e0 + 1 + 4 * k, 23'h60 + 23'(k));
        q_done.push_back(e0 + 17);
        goto(e0 + 2);
        divisor = 32'd9;
        start   = 1'b1;
        step();
        start   = 1'b0;
        goto(e0 + 17);
        divisor = 32'd4;

        // Top of address space: no wrap.
        issue(23'h7FFFFE, 23'h7FFFFF, 32'd3, e0);
        exp_rd(e0 + 1, 23'h7FFFFE);
        exp_rd(e0 + 4, 23'h7FFFFF);
        q_done.push_back(e0 + 7);
        goto(e0 + 7);
        chk("top rom_addr held", 32'(rom_addr), 32'h007FFFFF);
        chk("top busy", 32'(busy), 32'h0);
        step();

        // Reset mid-RUN; a dac_load otherwise due is suppressed.
        issue(23'h70, 23'h7F, 32'd2, e0);
        q_rd.push_back('{c: e0 + 1, a: 23'h70});
        q_dac.push_back(e0 + 2);
        q_rd.push_back('{c: e0 + 3, a: 23'h71});
        goto(e0 + 3);
        reset = 1'b1;
        step();
        chk("rst busy",     32'(busy),     32'h0);
        chk("rst rom_read", 32'(rom_read), 32'h0);
        chk("rst rom_addr", 32'(rom_addr), 32'h0);
        chk("rst dac_load", 32'(dac_load), 32'h0);
        chk("rst done",     32'(done),     32'h0);
        reset = 1'b0;
        issue(23'h8, 23'h8, 32'd2, e1);
        exp_rd(e1 + 1, 23'h8);
        q_done.push_back(e1 + 3);
        goto(e1 + 6);

        chk("rd queue drained",   32'(q_rd.size()),   32'h0);
        chk("dac queue drained",  32'(q_dac.size()),  32'h0);
        chk("done queue drained", 32'(q_done.size()), 32'h0);
        chk("err queue drained",  32'(q_err.size()),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
